// File: rtl/control_multi.sv
// Multicycle MIPS control FSM: sequences R/LW/SW/BEQ/ADDI over a shared memory port.
// Optional J support when CTRL_JUMP_EN is defined.
module control_multi #(
  parameter int OP_W  = 6,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [OP_W-1:0]  opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  localparam logic [OP_W-1:0] OP_R    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(8);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(35);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(43);
`ifdef CTRL_JUMP_EN
  localparam logic [OP_W-1:0] OP_J    = OP_W'(2);
`endif

  state_t st, nx;
  logic   is_sw_q;
  logic   set_ill;
  logic   inc;
  logic   unused_zero;

  // zero is consumed by the datapath through PCWriteCond
  assign unused_zero = zero;
  assign state       = st;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st         <= S_IDLE;
      is_sw_q    <= 1'b0;
      illegal_op <= 1'b0;
      retired    <= '0;
    end else begin
      st <= nx;
      if (st == S_DECODE)
        is_sw_q <= (opcode == OP_SW);
      if (set_ill)
        illegal_op <= 1'b1;
      if (inc)
        retired <= retired + 1'b1;
    end
  end

  always_comb begin
    nx          = st;
    set_ill     = 1'b0;
    inc         = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    case (st)
      S_IDLE: nx = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready)
          nx = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW,
          OP_SW:   nx = S_MEMADR;
          OP_R:    nx = S_EXEC;
          OP_BEQ:  nx = S_BRANCH;
          OP_ADDI: nx = S_ADDIEX;
`ifdef CTRL_JUMP_EN
          OP_J:    nx = S_JUMP;
`endif
          default: begin
            set_ill = 1'b1;
            nx      = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nx      = is_sw_q ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready)
          nx = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        inc      = 1'b1;
        nx       = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          inc = 1'b1;
          nx  = S_FETCH;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        nx      = S_RWB;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        inc      = 1'b1;
        nx       = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        inc         = 1'b1;
        nx          = S_FETCH;
      end
`ifdef CTRL_JUMP_EN
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        inc      = 1'b1;
        nx       = S_FETCH;
      end
`endif
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nx      = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        inc      = 1'b1;
        nx       = S_FETCH;
      end
      default: nx = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_multi.sv
// Bench for control_multi: directed sequences plus random traffic vs a path-list model.
// Honours CTRL_JUMP_EN the same way as the design.
module tb_control_multi;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic             IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]       ALUSrcB, ALUOp, PCSource;
  logic [3:0]       state;
  logic             illegal_op;
  logic [CNT_W-1:0] retired;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  control_multi #(.OP_W(6), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .illegal_op(illegal_op),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: after DECODE, an instruction is a list of remaining states;
  // states 4 (MEMRD) and 6 (MEMWR) hold until mem_ready.
  int  mst  = 0;
  bit  mill = 1'b0;
  int  mret = 0;
  int  path[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mst  = 0;
      mill = 1'b0;
      mret = 0;
      path.delete();
    end else if (mst == 0) begin
      mst = 1;
    end else if (mst == 1) begin
      if (mem_ready) mst = 2;
    end else if (mst == 2) begin
      path.delete();
      case (opcode)
        6'd0:  path = '{7, 8};
        6'd35: path = '{3, 4, 5};
        6'd43: path = '{3, 6};
        6'd4:  path = '{9};
        6'd8:  path = '{11, 12};
`ifdef CTRL_JUMP_EN
        6'd2:  path = '{10};
`endif
        default: mill = 1'b1;
      endcase
      mst = (path.size() != 0) ? path.pop_front() : 1;
    end else if ((mst == 4 || mst == 6) && !mem_ready) begin
      mst = mst;
    end else if (path.size() != 0) begin
      mst = path.pop_front();
    end else begin
      mret = (mret + 1) % (1 << CNT_W);
      mst  = 1;
    end
  end

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
  //  RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
  function automatic logic [15:0] exp_ctrl(input int s, input logic mr);
    case (s)
      1:  return {mr, 1'b0, 1'b0, 1'b1, 1'b0, mr, 4'b0000, 2'b01, 4'b0000};
      2:  return {10'b0, 2'b11, 4'b0000};
      3:  return {9'b0, 1'b1, 2'b10, 4'b0000};
      4:  return {2'b00, 2'b11, 12'b0};
      5:  return {6'b0, 1'b1, 1'b0, 1'b1, 7'b0};
      6:  return {2'b00, 1'b1, 1'b0, 1'b1, 11'b0};
      7:  return {9'b0, 1'b1, 2'b00, 2'b10, 2'b00};
      8:  return {7'b0, 2'b11, 7'b0};
      9:  return {1'b0, 1'b1, 7'b0, 1'b1, 2'b00, 2'b01, 2'b01};
      10: return {1'b1, 13'b0, 2'b10};
      11: return {9'b0, 1'b1, 2'b10, 4'b0000};
      12: return {8'b0, 1'b1, 7'b0};
      default: return 16'h0;
    endcase
  endfunction

  wire [15:0] ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                      IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
                      ALUSrcB, ALUOp, PCSource};

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("state", 32'(state), 32'(mst));
      chk("ctrl", 32'(ctrl), 32'(exp_ctrl(mst, mem_ready)));
      chk("illegal_op", 32'(illegal_op), 32'(mill));
      chk("retired", 32'(retired), 32'(mret));
      chk("rd_wr_excl", 32'(MemRead & MemWrite), 32'd0);
    end
  end

  task automatic cyc(input logic mr, input logic [5:0] op, input int exp_st);
    @(negedge clk);
    chk("seq_state", 32'(state), 32'(exp_st));
    #1;
    mem_ready = mr;
    opcode    = op;
    zero      = 1'($urandom);
  endtask

  int ops[8] = '{0, 35, 43, 4, 8, 2, 63, 17};

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    opcode    = 6'd0;
    zero      = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ctrl", 32'(ctrl), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    #1 reset_n = 1'b1;
    cmp_en = 1'b1;

    // R-type
    cyc(1, 0, 1);
    cyc(1, 0, 2);
    cyc(1, 0, 7);
    cyc(1, 0, 8);
    chk("rwb_regwrite", 32'(RegWrite), 32'd1);
    chk("rwb_regdst", 32'(RegDst), 32'd1);
    cyc(1, 35, 1);
    chk("r_retired", 32'(retired), 32'd1);
    // LW with three stall cycles in MEMRD
    cyc(1, 35, 2);
    cyc(1, 35, 3);
    cyc(0, 35, 4);
    chk("memrd_read", 32'({MemRead, IorD}), 32'd3);
    cyc(0, 35, 4);
    cyc(0, 35, 4);
    cyc(1, 35, 4);
    cyc(1, 4, 5);
    chk("memwb_m2r", 32'({RegWrite, MemtoReg, RegDst}), 32'b110);
    cyc(1, 4, 1);
    chk("lw_retired", 32'(retired), 32'd2);
    // BEQ
    cyc(1, 4, 2);
    cyc(1, 63, 9);
    chk("beq_ctrl", 32'({PCWriteCond, ALUOp, PCSource}), 32'b10101);
    cyc(1, 63, 1);
    chk("beq_retired", 32'(retired), 32'd3);
    // illegal 63
    cyc(1, 63, 2);
    cyc(1, 2, 1);
    chk("ill63_flag", 32'(illegal_op), 32'd1);
    chk("ill63_retired", 32'(retired), 32'd3);
    // opcode 2
    cyc(1, 2, 2);
`ifdef CTRL_JUMP_EN
    cyc(1, 43, 10);
    chk("jump_ctrl", 32'({PCWrite, PCSource}), 32'b110);
    cyc(1, 43, 1);
    chk("jump_wrap", 32'(retired), 32'd0);
`else
    cyc(1, 43, 1);
    chk("j_illegal", 32'(illegal_op), 32'd1);
    chk("j_retired", 32'(retired), 32'd3);
    chk("j_nopc", 32'(PCWrite), 32'(mem_ready));
`endif
    // SW, reset while in MEMWR
    cyc(1, 43, 2);
    cyc(0, 43, 3);
    cyc(0, 43, 6);
    chk("memwr_write", 32'({MemWrite, IorD}), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_memwrite", 32'(MemWrite), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_retired", 32'(retired), 32'd0);
    chk("arst_illegal", 32'(illegal_op), 32'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #1;
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) reset_n = 1'b0;
      mem_ready = ($urandom_range(0, 3) != 0);
      zero      = 1'($urandom);
      if (mst == 1) opcode = 6'(ops[$urandom_range(0, 7)]);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
